// File: rtl/mem_scan_ctrl_pkg.sv
// Shared definitions for the parity scan sequencer: width defaults, FSM state
// encoding and the fetch-select wrap helper.
package mem_scan_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF    = 4;
  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned ERR_CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } scan_state_e;

  // Increment an address modulo 2^width (width up to 32).
  function automatic int unsigned next_addr(input int unsigned addr, input int unsigned width);
    int unsigned mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (addr + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/mem_par_eval.sv
// Parity evaluator: flags a word whose XOR-reduction disagrees with its stored
// parity bit. Purely combinational so it can sit on any fetch path.
module mem_par_eval #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              par,
  output logic              word_err
);

  // Mismatch when the reduced data parity differs from the stored bit.
  always_comb begin
    word_err = (^data) != par;
  end

endmodule

// File: rtl/mem_scan_ctrl.sv
// Parity scan sequencer for the two-bank word store. Walks an inclusive,
// wrapping address window one word per clock, counts parity mismatches
// (saturating) and records the first failing address.
// Optional build macro MEM_SCAN_STOP_ON_ERR_EN: end the scan at the first
// mismatch instead of walking the full window.
module mem_scan_ctrl
  import mem_scan_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ERR_CNT_W = ERR_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W-1:0]    first_addr,
  input  logic [ADDR_W-1:0]    last_addr,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_data,
  input  logic                 mem_par,
  output logic                 busy,
  output logic                 done,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [ADDR_W-1:0]    first_err_addr
);

  localparam logic [ERR_CNT_W-1:0] CntMax = '1;

  scan_state_e          state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]    last_q, last_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 flag_q, flag_d;
  logic [ADDR_W-1:0]    ferr_q, ferr_d;
  logic                 word_err;

  mem_par_eval #(
    .DATA_W (DATA_W)
  ) u_par_eval (
    .data     (mem_data),
    .par      (mem_par),
    .word_err (word_err)
  );

  // Next-state and result bookkeeping for the IDLE/SCAN/DONE sequence.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    ferr_d  = ferr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = first_addr;
          last_d  = last_addr;
          cnt_d   = '0;
          flag_d  = 1'b0;
          ferr_d  = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        // The word on this edge is always checked, even when aborting.
        if (word_err) begin
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (!flag_q) begin
            flag_d = 1'b1;
            ferr_d = addr_q;
          end
        end
        if (abort) begin
          state_d = StIdle;
`ifdef MEM_SCAN_STOP_ON_ERR_EN
        end else if (word_err) begin
          // Flag is clear at scan start, so this is always the first mismatch.
          state_d = StDone;
`endif
        end else if (addr_q == last_q) begin
          state_d = StDone;
        end else begin
          addr_d = ADDR_W'(next_addr(32'(addr_q), ADDR_W));
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and result registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      ferr_q  <= ferr_d;
    end
  end

  // Status outputs decode straight from the registered state.
  always_comb begin
    busy           = (state_q == StScan);
    done           = (state_q == StDone);
    mem_addr       = addr_q;
    err_flag       = flag_q;
    err_cnt        = cnt_q;
    first_err_addr = ferr_q;
  end

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Self-checking bench for mem_scan_ctrl: a behavioural store feeds two
// instances (default counter width and a 3-bit counter); a reference model
// queues the expected address sequence and scan result for every start.
module tb_mem_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] first_addr = '0;
  logic [3:0] last_addr = '0;

  logic [3:0] mem_addr, mem_addr_s;
  logic [7:0] mem_data, mem_data_s;
  logic       mem_par, mem_par_s;
  logic       busy, done, err_flag;
  logic       busy_s, done_s, err_flag_s;
  logic [3:0] err_cnt;
  logic [2:0] err_cnt_s;
  logic [3:0] first_err_addr, first_err_addr_s;

  logic [7:0] mem_d [16];
  logic       mem_p [16];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    int unsigned words;
    int unsigned cnt;
    int unsigned cnt_sat;
    int unsigned flag;
    int unsigned ferr;
    int unsigned fin;
    int unsigned aborted;
  } res_t;

  res_t        res_q[$];
  int unsigned addr_q[$];

  always #5 clk = ~clk;

  assign mem_data   = mem_d[mem_addr];
  assign mem_par    = mem_p[mem_addr];
  assign mem_data_s = mem_d[mem_addr_s];
  assign mem_par_s  = mem_p[mem_addr_s];

  mem_scan_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .first_addr     (first_addr),
    .last_addr      (last_addr),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_par        (mem_par),
    .busy           (busy),
    .done           (done),
    .err_flag       (err_flag),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr)
  );

  mem_scan_ctrl #(
    .ERR_CNT_W (3)
  ) dut_sat (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .first_addr     (first_addr),
    .last_addr      (last_addr),
    .mem_addr       (mem_addr_s),
    .mem_data       (mem_data_s),
    .mem_par        (mem_par_s),
    .busy           (busy_s),
    .done           (done_s),
    .err_flag       (err_flag_s),
    .err_cnt        (err_cnt_s),
    .first_err_addr (first_err_addr_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Store with correct parity everywhere.
  task automatic store_clean();
    for (int i = 0; i < 16; i++) begin
      mem_d[i] = 8'((i * 37 + 5) & 255);
      mem_p[i] = ^mem_d[i];
    end
  endtask

  task automatic store_bad(input int unsigned idx);
    mem_p[idx] = ~(^mem_d[idx]);
  endtask

  // Reference model: queue expected addresses and final result.
  task automatic model(input int unsigned first, input int unsigned last,
                       input int unsigned abort_at);
    res_t        r;
    int unsigned a;
    bit          mm;
    r = '{default: 0};
    a = first;
    for (int i = 1; i <= 16; i++) begin
      addr_q.push_back(a);
      mm = ((^mem_d[a]) != mem_p[a]);
      r.words = i;
      r.fin   = a;
      if (mm) begin
        if (r.cnt < 15) r.cnt++;
        if (r.cnt_sat < 7) r.cnt_sat++;
        if (r.flag == 0) begin
          r.flag = 1;
          r.ferr = a;
        end
      end
      if (i == abort_at) begin
        r.aborted = 1;
        break;
      end
`ifdef MEM_SCAN_STOP_ON_ERR_EN
      if (mm) break;
`endif
      if (a == last) break;
      a = (a + 1) % 16;
    end
    res_q.push_back(r);
  endtask

  // Launch a scan, follow it cycle by cycle against the scoreboard.
  task automatic run_scan(input int unsigned first, input int unsigned last,
                          input int unsigned abort_at, input int unsigned restart_at);
    res_t        r;
    int unsigned busy_n;
    bit          ended;
    bit          done_seen;
    model(first, last, abort_at);
    @(negedge clk);
    first_addr = 4'(first);
    last_addr  = 4'(last);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_n = 0;
    ended = 0;
    done_seen = 0;
    for (int c = 1; c <= 40; c++) begin
      if (busy) begin
        busy_n++;
        if (addr_q.size() != 0) check("addr_seq", 32'(mem_addr), addr_q.pop_front());
        else check("addr_extra", 32'(busy), 0);
      end else begin
        done_seen = done;
        r = res_q.pop_front();
        check("end_cycle", c, r.words + 1);
        check("busy_cycles", busy_n, r.words);
        check("done_seen", 32'(done_seen), 32'(r.aborted == 0));
        check("err_cnt", 32'(err_cnt), r.cnt);
        check("err_flag", 32'(err_flag), r.flag);
        check("first_err", 32'(first_err_addr), r.ferr);
        check("final_addr", 32'(mem_addr), r.fin);
        check("sat_err_cnt", 32'(err_cnt_s), r.cnt_sat);
        ended = 1;
        break;
      end
      if (c == restart_at) begin
        first_addr = 4'd12;
        last_addr  = 4'd13;
        start      = 1'b1;
      end
      if (c == abort_at) abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
    end
    if (!ended) check("scan_timeout", 0, 1);
    check("addr_left", addr_q.size(), 0);
    @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
  endtask

  initial begin
    store_clean();
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_flag", 32'(err_flag), 0);
    check("rst_cnt", 32'(err_cnt), 0);
    check("rst_ferr", 32'(first_err_addr), 0);
    #20;
    @(negedge clk);
    reset = 1'b1;

    // 1: clean full window.
    run_scan(0, 15, 0, 0);

    // 2: two injected errors.
    mem_d[3] = 8'h75; mem_p[3] = 1'b0;
    mem_d[9] = 8'h22; mem_p[9] = 1'b1;
    run_scan(0, 15, 0, 0);

    // 3: wrapping window and single-word window.
    run_scan(14, 1, 0, 0);
    run_scan(5, 5, 0, 0);

    // 4: start ignored mid-scan; abort keeps partial results.
    run_scan(2, 10, 0, 3);
    run_scan(0, 15, 4, 0);

    // 5: reset mid-scan, then counter saturation.
    for (int i = 0; i < 16; i++) store_bad(i);
    @(negedge clk);
    first_addr = 4'd0;
    last_addr  = 4'd15;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_addr", 32'(mem_addr), 0);
    check("mid_rst_cnt", 32'(err_cnt), 0);
    check("mid_rst_flag", 32'(err_flag), 0);
    check("mid_rst_sat_cnt", 32'(err_cnt_s), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_done", 32'(done), 0);
    run_scan(0, 15, 0, 0);

    // 6: lone error at word 6.
    store_clean();
    store_bad(6);
    run_scan(0, 15, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
